// File: rtl/ita_step_sequencer.sv
// Step sequencer for one ITA layer: walks the layer's step list and issues each step once per tile.
// Optional feature: define ITA_SEQ_PERF_EN to add the perf_cycles_o busy-cycle counter.
module ita_step_sequencer #(
  parameter int TileW = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       layer_i,
  input  logic [TileW-1:0] tile_s_i,
  input  logic [TileW-1:0] tile_e_i,
  input  logic [TileW-1:0] tile_p_i,
  input  logic [TileW-1:0] tile_f_i,
  output logic [3:0]       step_o,
  output logic [TileW-1:0] tile_idx_o,
  output logic             step_valid_o,
  input  logic             step_ready_i,
  input  logic             step_done_i,
  output logic             busy_o,
  output logic             done_o
`ifdef ITA_SEQ_PERF_EN
  ,
  output logic [31:0]      perf_cycles_o
`endif
);

  typedef enum logic [1:0] {
    LAYER_ATTN   = 2'd0,
    LAYER_FF     = 2'd1,
    LAYER_LINEAR = 2'd2,
    LAYER_SINGLE = 2'd3
  } layer_e;

  typedef enum logic [3:0] {
    STEP_IDLE   = 4'd0,
    STEP_Q      = 4'd1,
    STEP_K      = 4'd2,
    STEP_V      = 4'd3,
    STEP_QK     = 4'd4,
    STEP_AV     = 4'd5,
    STEP_OW     = 4'd6,
    STEP_F1     = 4'd7,
    STEP_F2     = 4'd8,
    STEP_MATMUL = 4'd9
  } step_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_FINISH
  } state_e;

  function automatic step_e first_step(input layer_e layer);
    case (layer)
      LAYER_FF:     return STEP_F1;
      LAYER_LINEAR: return STEP_MATMUL;
      default:      return STEP_Q;
    endcase
  endfunction

  // STEP_IDLE marks the end of the layer's step list.
  function automatic step_e next_step(input layer_e layer, input step_e step);
    case (step)
      STEP_Q:  return STEP_K;
      STEP_K:  return STEP_V;
      STEP_V:  return STEP_QK;
      STEP_QK: return STEP_AV;
      STEP_AV: return (layer == LAYER_ATTN) ? STEP_OW : STEP_IDLE;
      STEP_F1: return STEP_F2;
      default: return STEP_IDLE;
    endcase
  endfunction

  function automatic logic [TileW-1:0] tile_count(
    input step_e            step,
    input logic [TileW-1:0] n_s,
    input logic [TileW-1:0] n_e,
    input logic [TileW-1:0] n_p,
    input logic [TileW-1:0] n_f
  );
    case (step)
      STEP_Q, STEP_K, STEP_V, STEP_OW: return n_e;
      STEP_QK, STEP_AV:                return n_s;
      STEP_F1, STEP_F2:                return n_f;
      STEP_MATMUL:                     return n_p;
      default:                         return '0;
    endcase
  endfunction

  state_e           state_q;
  layer_e           layer_q;
  step_e            step_q;
  logic [TileW-1:0] tile_s_q, tile_e_q, tile_p_q, tile_f_q;

  step_e            start_step, nxt_step;
  logic [TileW-1:0] start_n, cur_n, nxt_n;
  logic             last_tile, advance;

  assign start_step = first_step(layer_e'(layer_i));
  assign start_n    = tile_count(start_step, tile_s_i, tile_e_i, tile_p_i, tile_f_i);
  assign cur_n      = tile_count(step_q, tile_s_q, tile_e_q, tile_p_q, tile_f_q);
  assign nxt_step   = next_step(layer_q, step_q);
  assign nxt_n      = tile_count(nxt_step, tile_s_q, tile_e_q, tile_p_q, tile_f_q);
  assign last_tile  = (tile_idx_o == cur_n - TileW'(1));

  // A zero-count step is consumed by its single ISSUE evaluation cycle without a handshake.
  assign advance = ((state_q == S_ISSUE) && (cur_n == '0)) ||
                   ((state_q == S_WAIT) && step_done_i && last_tile);

  assign step_o = step_q;

  // NOTE: the latched layer config is cleared by reset too, so an aborted layer leaves no stale state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      layer_q      <= LAYER_ATTN;
      step_q       <= STEP_IDLE;
      tile_s_q     <= '0;
      tile_e_q     <= '0;
      tile_p_q     <= '0;
      tile_f_q     <= '0;
      tile_idx_o   <= '0;
      step_valid_o <= 1'b0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
    end else begin
      done_o <= 1'b0;
      if (advance) begin
        tile_idx_o <= '0;
        if (nxt_step == STEP_IDLE) begin
          state_q      <= S_FINISH;
          step_q       <= STEP_IDLE;
          step_valid_o <= 1'b0;
          done_o       <= 1'b1;
        end else begin
          state_q      <= S_ISSUE;
          step_q       <= nxt_step;
          step_valid_o <= (nxt_n != '0);
        end
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start_i) begin
              layer_q      <= layer_e'(layer_i);
              tile_s_q     <= tile_s_i;
              tile_e_q     <= tile_e_i;
              tile_p_q     <= tile_p_i;
              tile_f_q     <= tile_f_i;
              step_q       <= start_step;
              tile_idx_o   <= '0;
              step_valid_o <= (start_n != '0);
              busy_o       <= 1'b1;
              state_q      <= S_ISSUE;
            end
          end
          S_ISSUE: begin
            if (step_ready_i) begin
              step_valid_o <= 1'b0;
              state_q      <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (step_done_i) begin
              tile_idx_o   <= tile_idx_o + TileW'(1);
              step_valid_o <= 1'b1;
              state_q      <= S_ISSUE;
            end
          end
          default: begin
            busy_o  <= 1'b0;
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

`ifdef ITA_SEQ_PERF_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perf_cycles_o <= '0;
    end else if ((state_q == S_IDLE) && start_i) begin
      perf_cycles_o <= '0;
    end else if (busy_o && (perf_cycles_o != '1)) begin
      perf_cycles_o <= perf_cycles_o + 32'd1;
    end
  end
`endif

endmodule
